csr_regfile: RTL and testbench
==============================

// Module: csr_regfile
// PURPOSE
//  Parametrised CSR slave register bank on the csr_if slave signal set (addr/be/wr_data/wr_en/rd_data),
//  extended with rd_en/rd_valid and per-register access modes (RW, RO, W1C sticky, PULSE).
//  Sits between the CPU-bridge CSR master and a datapath block. It holds control registers,
//  latches status events, and returns read data with a configurable registered latency.
// PARAMETERS
//  A_WIDTH     10          address width (word address)
//  D_WIDTH     16          data width; must equal 8*BE_WIDTH
//  BE_WIDTH    2           byte-enable width
//  NUM_REGS    8           number of registers, addresses 0..NUM_REGS-1; must be <= 2**A_WIDTH
//  REG_MODE    '0          2*NUM_REGS bits, reg i at [2i+1:2i]: 0=RW, 1=RO, 2=W1C, 3=PULSE
//  RESET_VAL   '0          NUM_REGS*D_WIDTH bits, reg i at [i*D_WIDTH +: D_WIDTH]; used by RW/W1C
//  RD_LATENCY  1           1 or 2 cycles from rd_en to rd_valid
// PORTS
//  clk        in   1                  clock
//  rst        in   1                  asynchronous reset, active-high
//  addr       in   A_WIDTH            register word address
//  be         in   BE_WIDTH           byte enables for writes; bit k enables wr_data[8k+7:8k]
//  wr_data    in   D_WIDTH            write data
//  wr_en      in   1                  write strobe, one cycle per write
//  rd_en      in   1                  read strobe, one cycle per read
//  rd_data    out  D_WIDTH            read data, valid when rd_valid=1, held otherwise
//  rd_valid   out  1                  one-cycle read-data qualifier
//  regs_o     out  NUM_REGS*D_WIDTH   current register contents (RW: stored, PULSE: pulse value)
//  status_i   in   NUM_REGS*D_WIDTH   RO: live value; W1C: per-bit set requests (level, sampled each clk)
//  pulse_o    out  NUM_REGS           per-register one-cycle strobe on any write to a PULSE reg
// BEHAVIOUR
//  Reset (async assert, sync-released usage assumed by system): RW/W1C regs <= RESET_VAL; PULSE regs,
//   pulse_o, rd_valid, rd_data, and read pipeline <= 0.
//  Write (wr_en=1, addr<NUM_REGS), effective at the next clk edge, per enabled byte lane only:
//   RW    : reg[lane] <= wr_data[lane].
//   RO    : ignored.
//   W1C   : reg bit <= 0 where wr_data bit=1 and its lane enabled; all other bits hold.
//   PULSE : regs_o lane bits = wr_data for exactly one cycle after the edge, then 0; pulse_o[i]=1 for
//           that same cycle (even if be=0). The next write extends or repeats the pulse.
//  W1C set: every cycle reg |= status_i slice. Set and clear of the same bit in the same cycle: set wins (bit=1).
//  Read: rd_en=1 samples addr. Data is captured at that edge and output by RD_LATENCY.
//   RD_LATENCY=1: rd_data/rd_valid update on the edge after rd_en. RD_LATENCY=2: one extra register stage.
//   Read value: RW/W1C = register contents before any same-cycle write (read-before-write);
//               RO = status_i slice sampled at the rd_en edge; PULSE = 0.
//   Back-to-back rd_en every cycle is supported: one rd_valid per rd_en, in order, no bubbles.
//   rd_data holds its last value while rd_valid=0.
//  Out-of-range addr (>= NUM_REGS): writes are ignored with no pulse. Reads return 0 with rd_valid asserted normally.
//  wr_en and rd_en in the same cycle are both serviced; the read follows the read-before-write rule.
//  Reset mid-read: any in-flight rd_valid is dropped, and no rd_valid appears after reset release for earlier reads.
//  Elaboration: $error if D_WIDTH != 8*BE_WIDTH, RD_LATENCY not in {1,2}, or NUM_REGS > 2**A_WIDTH.
// TESTING (NUM_REGS=4, REG_MODE: r0=RW r1=RO r2=W1C r3=PULSE, RESET_VAL r0=16'h1234, RD_LATENCY=1 unless noted)
//  1 reset, read addr0 -> rd_valid 1 cycle later with rd_data=16'h1234. Write addr0 16'hABCD with be=2'b01 -> read 16'h12CD.
//  2 status_i r1=16'h5A5A, read addr1 -> 16'h5A5A. Write addr1 16'hFFFF, then read -> still live status value.
//  3 pulse status_i r2 bit3 for 1 cycle -> read r2=16'h0008. Write 16'h0008 -> read 16'h0000.
//    Write 16'h0008 with status bit3 high in the same cycle -> bit stays 1.
//  4 write addr3 16'h0005 be=2'b00 -> pulse_o[3]=1 for exactly one cycle with regs_o r3=0. Read addr3 -> 0.
//  5 RD_LATENCY=2, rd_en on 4 consecutive cycles at addrs 0,1,2,7 -> 4 consecutive rd_valid 2 cycles later
//    in order; addr7 returns 16'h0000; the write to addr7 is ignored.
//  6 assert rst between rd_en and rd_valid -> no rd_valid is produced. All outputs are at reset values
//    while rst=1 and on the first cycle after release.

Source files
------------

// File: rtl/csr_if.sv
// CSR slave bus: word address, byte-enabled writes, strobed reads with a
// one-cycle read-data qualifier.
interface csr_if #(
  parameter int A_WIDTH  = 10,
  parameter int D_WIDTH  = 16,
  parameter int BE_WIDTH = 2
) ();
  logic [A_WIDTH-1:0]  addr;
  logic [BE_WIDTH-1:0] be;
  logic [D_WIDTH-1:0]  wr_data;
  logic                wr_en;
  logic                rd_en;
  logic [D_WIDTH-1:0]  rd_data;
  logic                rd_valid;

  modport master (
    output addr, be, wr_data, wr_en, rd_en,
    input  rd_data, rd_valid
  );

  modport slave (
    input  addr, be, wr_data, wr_en, rd_en,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/csr_regfile.sv
// Parametrised CSR register bank with per-register RW / RO / W1C / PULSE modes
// and a 1- or 2-cycle registered read path.
module csr_regfile #(
  parameter int                          A_WIDTH    = 10,
  parameter int                          D_WIDTH    = 16,
  parameter int                          BE_WIDTH   = 2,
  parameter int                          NUM_REGS   = 8,
  parameter logic [2*NUM_REGS-1:0]       REG_MODE   = {(2*NUM_REGS){1'b0}},
  parameter logic [NUM_REGS*D_WIDTH-1:0] RESET_VAL  = {(NUM_REGS*D_WIDTH){1'b0}},
  parameter int                          RD_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  csr_if.slave                         bus,
  output logic [NUM_REGS*D_WIDTH-1:0]  regs_o,
  input  logic [NUM_REGS*D_WIDTH-1:0]  status_i,
  output logic [NUM_REGS-1:0]          pulse_o
);

  localparam logic [1:0] MODE_RW    = 2'd0;
  localparam logic [1:0] MODE_RO    = 2'd1;
  localparam logic [1:0] MODE_W1C   = 2'd2;
  localparam logic [1:0] MODE_PULSE = 2'd3;
  localparam int         IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  if (D_WIDTH != 8 * BE_WIDTH) begin : g_bad_width
    $error("csr_regfile: D_WIDTH must equal 8*BE_WIDTH");
  end
  if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
    $error("csr_regfile: RD_LATENCY must be 1 or 2");
  end
  if (64'(NUM_REGS) > (64'd1 << A_WIDTH)) begin : g_bad_regs
    $error("csr_regfile: NUM_REGS exceeds the address space");
  end

  function automatic logic [D_WIDTH-1:0] lane_mask(input logic [BE_WIDTH-1:0] be_v);
    logic [D_WIDTH-1:0] m;
    m = {D_WIDTH{1'b0}};
    for (int k = 0; k < BE_WIDTH; k++) begin
      m[8*k +: 8] = {8{be_v[k]}};
    end
    return m;
  endfunction

  function automatic logic [1:0] mode_of(input int idx);
    return REG_MODE[2*idx +: 2];
  endfunction

  // RO registers have no storage; PULSE registers idle at zero.
  function automatic logic [D_WIDTH-1:0] reset_of(input int idx);
    logic [D_WIDTH-1:0] v;
    if ((mode_of(idx) == MODE_RW) || (mode_of(idx) == MODE_W1C)) begin
      v = RESET_VAL[idx*D_WIDTH +: D_WIDTH];
    end else begin
      v = {D_WIDTH{1'b0}};
    end
    return v;
  endfunction

  logic [D_WIDTH-1:0]  reg_r       [NUM_REGS];
  logic [D_WIDTH-1:0]  reg_nxt_s   [NUM_REGS];
  logic [D_WIDTH-1:0]  rd_word_s   [NUM_REGS];
  logic [D_WIDTH-1:0]  wr_bits_s   [NUM_REGS];
  logic [D_WIDTH-1:0]  wr_mask_s   [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit_s;
  logic [NUM_REGS-1:0] pulse_r;
  logic [NUM_REGS-1:0] pulse_nxt_s;
  logic [D_WIDTH-1:0]  be_mask_s;
  logic [D_WIDTH-1:0]  rd_mux_s;
  logic                rd_v1_r;
  logic [D_WIDTH-1:0]  rd_d1_r;

  // Per-register next state and read word; reads see pre-write contents.
  always_comb begin
    be_mask_s = lane_mask(bus.be);
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_hit_s[i]    = bus.wr_en && (bus.addr == A_WIDTH'(i));
      wr_mask_s[i]   = wr_hit_s[i] ? be_mask_s : {D_WIDTH{1'b0}};
      wr_bits_s[i]   = bus.wr_data & wr_mask_s[i];
      reg_nxt_s[i]   = reg_r[i];
      pulse_nxt_s[i] = 1'b0;
      rd_word_s[i]   = {D_WIDTH{1'b0}};
      case (mode_of(i))
        MODE_RW: begin
          reg_nxt_s[i] = (reg_r[i] & ~wr_mask_s[i]) | wr_bits_s[i];
          rd_word_s[i] = reg_r[i];
        end
        MODE_RO: begin
          reg_nxt_s[i] = {D_WIDTH{1'b0}};
          rd_word_s[i] = status_i[i*D_WIDTH +: D_WIDTH];
        end
        MODE_W1C: begin
          // OR-ing the set after the clear makes a same-cycle set win.
          reg_nxt_s[i] = (reg_r[i] & ~wr_bits_s[i]) | status_i[i*D_WIDTH +: D_WIDTH];
          rd_word_s[i] = reg_r[i];
        end
        MODE_PULSE: begin
          reg_nxt_s[i]   = wr_bits_s[i];
          pulse_nxt_s[i] = wr_hit_s[i];
        end
        default: begin
          reg_nxt_s[i] = reg_r[i];
        end
      endcase
    end
  end

  // Register storage and pulse strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_r[i] <= reset_of(i);
      end
      pulse_r <= {NUM_REGS{1'b0}};
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_r[i] <= reg_nxt_s[i];
      end
      pulse_r <= pulse_nxt_s;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[g*D_WIDTH +: D_WIDTH] = reg_r[g];
  end
  assign pulse_o = pulse_r;

  // Read address decode; out-of-range addresses read as zero.
  always_comb begin
    if ({1'b0, bus.addr} < (A_WIDTH + 1)'(NUM_REGS)) begin
      rd_mux_s = rd_word_s[bus.addr[IDX_W-1:0]];
    end else begin
      rd_mux_s = {D_WIDTH{1'b0}};
    end
  end

  // First read stage: data only moves on a read so it holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_v1_r <= 1'b0;
      rd_d1_r <= {D_WIDTH{1'b0}};
    end else begin
      rd_v1_r <= bus.rd_en;
      if (bus.rd_en) begin
        rd_d1_r <= rd_mux_s;
      end else begin
        rd_d1_r <= rd_d1_r;
      end
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic               rd_v2_r;
    logic [D_WIDTH-1:0] rd_d2_r;

    // Extra read stage for timing; follows stage 1 one cycle later.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_v2_r <= 1'b0;
        rd_d2_r <= {D_WIDTH{1'b0}};
      end else begin
        rd_v2_r <= rd_v1_r;
        if (rd_v1_r) begin
          rd_d2_r <= rd_d1_r;
        end else begin
          rd_d2_r <= rd_d2_r;
        end
      end
    end

    assign bus.rd_valid = rd_v2_r;
    assign bus.rd_data  = rd_d2_r;
  end else begin : g_lat1
    assign bus.rd_valid = rd_v1_r;
    assign bus.rd_data  = rd_d1_r;
  end

endmodule

// File: tb/tb_csr_regfile.sv
// Bench for csr_regfile: two instances (read latency 1 and 2) share one stimulus
// stream and are checked every cycle against a behavioural register-bank model.
module tb_csr_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  addr = 10'd0;
  logic [1:0]  be = 2'b00;
  logic [15:0] wr_data = 16'h0000;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [63:0] status = 64'h0;
  logic [63:0] regs1, regs2;
  logic [3:0]  pulse1, pulse2;

  int n_cmp = 0;
  int n_bad = 0;

  csr_if #(.A_WIDTH(10), .D_WIDTH(16), .BE_WIDTH(2)) bus1 ();
  csr_if #(.A_WIDTH(10), .D_WIDTH(16), .BE_WIDTH(2)) bus2 ();

  assign bus1.addr = addr;  assign bus2.addr = addr;
  assign bus1.be = be;      assign bus2.be = be;
  assign bus1.wr_data = wr_data; assign bus2.wr_data = wr_data;
  assign bus1.wr_en = wr_en; assign bus2.wr_en = wr_en;
  assign bus1.rd_en = rd_en; assign bus2.rd_en = rd_en;

  csr_regfile #(.A_WIDTH(10), .D_WIDTH(16), .BE_WIDTH(2), .NUM_REGS(4),
                .REG_MODE(8'b11_10_01_00), .RESET_VAL(64'h0000_0000_0000_1234),
                .RD_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave), .regs_o(regs1), .status_i(status), .pulse_o(pulse1));

  csr_regfile #(.A_WIDTH(10), .D_WIDTH(16), .BE_WIDTH(2), .NUM_REGS(4),
                .REG_MODE(8'b11_10_01_00), .RESET_VAL(64'h0000_0000_0000_1234),
                .RD_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave), .regs_o(regs2), .status_i(status), .pulse_o(pulse2));

  always #5 clk = ~clk;

  // Model state: r0 RW contents, r2 W1C contents, r3 current pulse value.
  logic [15:0] m_reg [4];
  logic [3:0]  m_pulse;
  logic [16:0] hist [$];          // {valid, data} of the read sampled at each edge, newest first
  logic        exp_v [2];
  logic [15:0] exp_d [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [15:0] mask, rv, clr;
    logic        wr0, wr2, wr3;
    if (rst) begin
      m_reg[0] = 16'h1234; m_reg[1] = 16'h0; m_reg[2] = 16'h0; m_reg[3] = 16'h0;
      m_pulse = 4'b0;
      hist.delete();
      for (int l = 0; l < 2; l++) begin exp_v[l] = 1'b0; exp_d[l] = 16'h0; end
    end else begin
      mask = {{8{be[1]}}, {8{be[0]}}};
      case (addr)
        10'd0:   rv = m_reg[0];
        10'd1:   rv = status[31:16];
        10'd2:   rv = m_reg[2];
        default: rv = 16'h0;
      endcase
      hist.push_front({rd_en, rv});
      if (hist.size() > 2) void'(hist.pop_back());
      wr0 = wr_en && (addr == 10'd0);
      wr2 = wr_en && (addr == 10'd2);
      wr3 = wr_en && (addr == 10'd3);
      if (wr0) m_reg[0] = (m_reg[0] & ~mask) | (wr_data & mask);
      clr = wr2 ? (wr_data & mask) : 16'h0;
      m_reg[2] = (m_reg[2] & ~clr) | status[47:32];
      m_reg[3] = wr3 ? (wr_data & mask) : 16'h0;
      m_pulse  = wr3 ? 4'b1000 : 4'b0000;
      for (int l = 0; l < 2; l++) begin
        if (hist.size() > l && hist[l][16]) begin
          exp_v[l] = 1'b1;
          exp_d[l] = hist[l][15:0];
        end else begin
          exp_v[l] = 1'b0;
        end
      end
    end
  endtask

  // Single compare process: advance the model on each edge, check just after.
  always @(posedge clk) begin
    model_step();
    #1;
    check("rd_valid_l1", 64'(bus1.rd_valid), 64'(exp_v[0]));
    check("rd_data_l1",  64'(bus1.rd_data),  64'(exp_d[0]));
    check("rd_valid_l2", 64'(bus2.rd_valid), 64'(exp_v[1]));
    check("rd_data_l2",  64'(bus2.rd_data),  64'(exp_d[1]));
    check("regs_r0", 64'(regs1[15:0]),  64'(m_reg[0]));
    check("regs_r2", 64'(regs1[47:32]), 64'(m_reg[2]));
    check("regs_r3", 64'(regs1[63:48]), 64'(m_reg[3]));
    check("pulse_l1", 64'(pulse1), 64'(m_pulse));
    check("regs_l2_match", {regs2[63:32], regs2[15:0]}, {m_reg[3], m_reg[2], m_reg[0]});
    check("pulse_l2", 64'(pulse2), 64'(m_pulse));
  end

  task automatic do_wr(input logic [9:0] a, input logic [15:0] d, input logic [1:0] b);
    @(negedge clk);
    addr = a; wr_data = d; be = b; wr_en = 1'b1; rd_en = 1'b0;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_rd(input string name, input logic [9:0] a, input logic [15:0] exp);
    @(negedge clk);
    addr = a; rd_en = 1'b1; wr_en = 1'b0;
    @(negedge clk);
    rd_en = 1'b0;
    check({name, "_v1"}, 64'(bus1.rd_valid), 64'd1);
    check({name, "_d1"}, 64'(bus1.rd_data), 64'(exp));
    @(negedge clk);
    check({name, "_v2"}, 64'(bus2.rd_valid), 64'd1);
    check({name, "_d2"}, 64'(bus2.rd_data), 64'(exp));
  endtask

  logic [9:0]  burst_addr [4];
  logic [15:0] burst_exp  [4];

  initial begin
    burst_addr[0] = 10'd0; burst_addr[1] = 10'd1; burst_addr[2] = 10'd2; burst_addr[3] = 10'd7;
    burst_exp[0] = 16'h12CD; burst_exp[1] = 16'h5A5A; burst_exp[2] = 16'h0008; burst_exp[3] = 16'h0000;

    repeat (3) @(negedge clk);
    check("reset_regs", regs1, 64'h0000_0000_0000_1234);
    check("reset_rdv", 64'(bus1.rd_valid), 64'd0);
    rst = 1'b0;

    // Reset value and byte-lane write on the RW register.
    do_rd("rd_r0_reset", 10'd0, 16'h1234);
    do_wr(10'd0, 16'hABCD, 2'b01);
    do_rd("rd_r0_lane", 10'd0, 16'h12CD);

    // RO register reads live status and ignores writes.
    status[31:16] = 16'h5A5A;
    do_rd("rd_r1", 10'd1, 16'h5A5A);
    do_wr(10'd1, 16'hFFFF, 2'b11);
    do_rd("rd_r1_after_wr", 10'd1, 16'h5A5A);

    // W1C: sticky set, clear, then set winning over a same-cycle clear.
    @(negedge clk); status[47:32] = 16'h0008;
    @(negedge clk); status[47:32] = 16'h0000;
    do_rd("rd_r2_set", 10'd2, 16'h0008);
    do_wr(10'd2, 16'h0008, 2'b11);
    do_rd("rd_r2_clr", 10'd2, 16'h0000);
    @(negedge clk);
    addr = 10'd2; wr_data = 16'h0008; be = 2'b11; wr_en = 1'b1; status[47:32] = 16'h0008;
    @(negedge clk);
    wr_en = 1'b0; status[47:32] = 16'h0000;
    do_rd("rd_r2_setwins", 10'd2, 16'h0008);

    // PULSE register: strobe even with no lanes enabled, value only for one cycle.
    @(negedge clk); addr = 10'd3; wr_data = 16'h0005; be = 2'b00; wr_en = 1'b1;
    @(negedge clk); wr_en = 1'b0;
    check("pulse_be0", 64'(pulse1), 64'h8);
    check("pulse_be0_val", 64'(regs1[63:48]), 64'h0);
    @(negedge clk);
    check("pulse_be0_end", 64'(pulse1), 64'h0);
    @(negedge clk); addr = 10'd3; wr_data = 16'h0005; be = 2'b11; wr_en = 1'b1;
    @(negedge clk); wr_en = 1'b0;
    check("pulse_val", 64'(regs1[63:48]), 64'h5);
    @(negedge clk);
    check("pulse_val_end", 64'(regs1[63:48]), 64'h0);
    do_rd("rd_r3", 10'd3, 16'h0000);

    // Back-to-back reads including out-of-range addr 7, written in the same cycle.
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k >= 1 && k <= 4) begin
        check("burst_v1", 64'(bus1.rd_valid), 64'd1);
        check("burst_d1", 64'(bus1.rd_data), 64'(burst_exp[k-1]));
      end else begin
        check("burst_v1_idle", 64'(bus1.rd_valid), 64'd0);
      end
      if (k >= 2 && k <= 5) begin
        check("burst_v2", 64'(bus2.rd_valid), 64'd1);
        check("burst_d2", 64'(bus2.rd_data), 64'(burst_exp[k-2]));
      end else begin
        check("burst_v2_idle", 64'(bus2.rd_valid), 64'd0);
      end
      if (k < 4) begin
        addr = burst_addr[k]; rd_en = 1'b1;
        wr_en = (k == 3); wr_data = 16'hFFFF; be = 2'b11;
      end else begin
        rd_en = 1'b0; wr_en = 1'b0;
      end
    end
    do_rd("rd_oor", 10'd7, 16'h0000);

    // Reset before the capture edge: nothing comes out.
    @(negedge clk); addr = 10'd0; rd_en = 1'b1;
    #3 rst = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    check("rst_rdv1", 64'(bus1.rd_valid), 64'd0);
    check("rst_rdd1", 64'(bus1.rd_data), 64'd0);
    check("rst_regs", regs1, 64'h0000_0000_0000_1234);
    @(negedge clk); rst = 1'b0;
    check("rst_rdv2", 64'(bus2.rd_valid), 64'd0);
    @(negedge clk);
    check("rel_rdv1", 64'(bus1.rd_valid), 64'd0);
    check("rel_rdv2", 64'(bus2.rd_valid), 64'd0);
    check("rel_pulse", 64'(pulse1), 64'd0);
    check("rel_regs", regs2, 64'h0000_0000_0000_1234);

    // Reset between capture and the second stage drops the latency-2 read.
    @(negedge clk); addr = 10'd1; rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0; rst = 1'b1;
    #1 check("midrst_v2", 64'(bus2.rd_valid), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("midrst_v2_after", 64'(bus2.rd_valid), 64'd0);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst     = ($urandom_range(0, 63) == 0);
      addr    = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'($urandom_range(0, 4));
      be      = 2'($urandom);
      wr_data = 16'($urandom);
      wr_en   = 1'($urandom);
      rd_en   = ($urandom_range(0, 3) != 0);
      status[31:16] = 16'($urandom);
      status[47:32] = 16'($urandom) & 16'($urandom) & 16'($urandom);
      status[15:0]  = 16'($urandom);
      status[63:48] = 16'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
